// File: rtl/timer0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer0_pkg
// Brief    : Shared widths and the PS[2:0] -> prescaler terminal-count helper.
// Revision : 1.0
// ============================================================================
package timer0_pkg;

  localparam int TMR_W     = 8;
  localparam int PRE_W     = 8;
  localparam int INSTR_DIV = 4;
  localparam int PHASE_W   = 2;

  // Terminal count 2^(PS+1)-1; PS=7 relies on the 8-bit wrap to give FF.
  function automatic logic [PRE_W-1:0] ps_terminal(input logic [2:0] ps);
    logic [PRE_W-1:0] one;
    one = PRE_W'(1);
    return ((one << ps) << 1) - one;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer0_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : timer0_prescaler
// Brief    : Divides the Timer0 source tick by 2^(PS+1), or bypasses when psa=1.
// Revision : 1.0
// ============================================================================
module timer0_prescaler
  import timer0_pkg::*;
(
  input  logic       fosc,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       psa,
  input  logic [2:0] ps,
  input  logic       clear,
  output logic       strobe
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [PRE_W-1:0] term;

  always_comb begin
    term   = ps_terminal(ps);
    pre_d  = pre_q;
    strobe = 1'b0;
    if (clear) begin
      pre_d = '0;
    end else if (psa) begin
      pre_d  = '0;
      strobe = tick;
    end else if (tick) begin
      if (pre_q == term) begin
        pre_d  = '0;
        strobe = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge fosc) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pic_timer0.sv
`default_nettype none
// ============================================================================
// Module   : pic_timer0
// Brief    : PIC16-style Timer0 with fosc/4 or T0CKI source and prescaler.
//            Define TIMER0_SYNC_EN for a two-flop T0CKI synchronizer.
// Revision : 1.0
// ============================================================================
module pic_timer0
  import timer0_pkg::*;
(
  input  logic             fosc,
  input  logic             rst_n,
  input  logic             ps2,
  input  logic             ps1,
  input  logic             ps0,
  input  logic             psa,
  input  logic             t0cs,
  input  logic             t0se,
  input  logic             t0clk,
  output logic [TMR_W-1:0] tmr0,
  output logic             overflow
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(INSTR_DIV - 1);
  localparam int                 CFG_W      = 6;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d, cfg_now;
  logic               smp_q, smp_d;
  logic               hist_q, hist_d;
  logic [TMR_W-1:0]   tmr0_q, tmr0_d;
  logic               overflow_q, overflow_d;
`ifdef TIMER0_SYNC_EN
  logic               meta_q, meta_d;
`endif

  logic [2:0] ps;
  logic       int_tick;
  logic       ext_tick;
  logic       src_tick;
  logic       cfg_change;
  logic       strobe;

  always_comb begin
    ps         = {ps2, ps1, ps0};
    cfg_now    = {ps, psa, t0cs, t0se};
    cfg_d      = cfg_now;
    cfg_change = (cfg_now != cfg_q);
    phase_d    = phase_q + PHASE_W'(1);
    int_tick   = (phase_q == PHASE_LAST);
`ifdef TIMER0_SYNC_EN
    meta_d     = t0clk;
    smp_d      = meta_q;
`else
    smp_d      = t0clk;
`endif
    hist_d     = smp_q;
    ext_tick   = t0se ? (hist_q & ~smp_q) : (smp_q & ~hist_q);
    src_tick   = t0cs ? ext_tick : int_tick;
    tmr0_d     = strobe ? (tmr0_q + TMR_W'(1)) : tmr0_q;
    // Registered alongside tmr0 so the pulse lands in the cycle tmr0 reads 00.
    overflow_d = strobe && (tmr0_q == '1);
  end

  timer0_prescaler u_prescaler (
    .fosc   (fosc),
    .rst_n  (rst_n),
    .tick   (src_tick),
    .psa    (psa),
    .ps     (ps),
    .clear  (cfg_change),
    .strobe (strobe)
  );

  always_ff @(posedge fosc) begin
    if (!rst_n) begin
      phase_q    <= '0;
      cfg_q      <= cfg_now;
      smp_q      <= 1'b0;
      hist_q     <= 1'b0;
      tmr0_q     <= '0;
      overflow_q <= 1'b0;
`ifdef TIMER0_SYNC_EN
      meta_q     <= 1'b0;
`endif
    end else begin
      phase_q    <= phase_d;
      cfg_q      <= cfg_d;
      smp_q      <= smp_d;
      hist_q     <= hist_d;
      tmr0_q     <= tmr0_d;
      overflow_q <= overflow_d;
`ifdef TIMER0_SYNC_EN
      meta_q     <= meta_d;
`endif
    end
  end

  assign tmr0     = tmr0_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_timer0.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_timer0
// Brief    : Self-checking bench for pic_timer0 against an event-count model.
// Revision : 1.0
// ============================================================================
module tb_pic_timer0;

  logic       fosc  = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2   = 1'b0;
  logic       ps1   = 1'b0;
  logic       ps0   = 1'b0;
  logic       psa   = 1'b1;
  logic       t0cs  = 1'b0;
  logic       t0se  = 1'b0;
  logic       t0clk = 1'b0;
  logic [7:0] tmr0;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int n      = 0;    // rising edges since the reset edge
  int cnt    = 0;    // selected pin edges that should have reached tmr0
  int due[$];        // edge index at which each pending pin edge lands

`ifdef TIMER0_SYNC_EN
  localparam int EXT_LAT = 3;
`else
  localparam int EXT_LAT = 2;
`endif

  pic_timer0 dut (
    .fosc     (fosc),
    .rst_n    (rst_n),
    .ps2      (ps2),
    .ps1      (ps1),
    .ps0      (ps0),
    .psa      (psa),
    .t0cs     (t0cs),
    .t0se     (t0se),
    .t0clk    (t0clk),
    .tmr0     (tmr0),
    .overflow (overflow)
  );

  always #5 fosc = ~fosc;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic set_ps(input int v);
    {ps2, ps1, ps0} = 3'(v);
  endtask

  task automatic step();
    @(posedge fosc);
    #1;
    n++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge fosc);
    #1;
    rst_n = 1'b1;
    n     = 0;
  endtask

  // Internal source: one tick per 4 cycles, one increment per 'ratio' ticks.
  function automatic logic [7:0] int_model(input int edges, input int ratio);
    return 8'((edges / (4 * ratio)) % 256);
  endfunction

  function automatic logic int_ovf(input int edges, input int ratio);
    return (edges > 0) && (edges % (1024 * ratio) == 0);
  endfunction

  task automatic pop_due();
    while (due.size() > 0 && due[0] <= n) begin
      void'(due.pop_front());
      cnt++;
    end
  endtask

  task automatic test_reset();
    t0cs  = 1'b0;
    psa   = 1'($urandom_range(0, 1));
    set_ps($urandom_range(0, 7));
    t0clk = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge fosc);
      #1;
      checks++;
      if (tmr0 !== 8'h00) begin
        errors++;
        $display("FAIL reset_tmr0 cycle %0d: got %h expected 00", i, tmr0);
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_overflow cycle %0d: got %b expected 0", i, overflow);
      end
    end
    rst_n = 1'b1;
    n     = 0;
  endtask

  task automatic test_bypass_internal();
    logic [7:0] exp_t;
    logic       exp_o;
    t0cs = 1'b0;
    psa  = 1'b1;
    set_ps($urandom_range(0, 7));
    do_reset();
    for (int i = 0; i < 1100; i++) begin
      step();
      exp_t = int_model(n, 1);
      exp_o = int_ovf(n, 1);
      checks++;
      if (tmr0 !== exp_t) begin
        errors++;
        if (errors < 20) $display("FAIL bypass_tmr0 n=%0d: got %h expected %h", n, tmr0, exp_t);
      end
      checks++;
      if (overflow !== exp_o) begin
        errors++;
        if (errors < 20) $display("FAIL bypass_ovf n=%0d: got %b expected %b", n, overflow, exp_o);
      end
    end
  endtask

  task automatic test_prescale(input int psv, input int cycles);
    logic [7:0] exp_t;
    logic       exp_o;
    int         ratio;
    ratio = 2 << psv;
    t0cs  = 1'b0;
    psa   = 1'b0;
    set_ps(psv);
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      step();
      exp_t = int_model(n, ratio);
      exp_o = int_ovf(n, ratio);
      checks++;
      if (tmr0 !== exp_t) begin
        errors++;
        if (errors < 20) $display("FAIL prescale_ps%0d_tmr0 n=%0d: got %h expected %h", psv, n, tmr0, exp_t);
      end
      checks++;
      if (overflow !== exp_o) begin
        errors++;
        if (errors < 20) $display("FAIL prescale_ps%0d_ovf n=%0d: got %b expected %b", psv, n, overflow, exp_o);
      end
    end
  endtask

  task automatic test_ext_directed();
    t0cs  = 1'b1;
    psa   = 1'b1;
    t0se  = 1'b0;
    t0clk = 1'b0;
    do_reset();
    due.delete();
    cnt = 0;
    for (int e = 0; e < 10; e++) begin
      for (int p = 0; p < 8; p++) begin
        if (p == 0) begin
          t0clk = 1'b1;
          due.push_back(n + EXT_LAT);
        end
        if (p == 4) t0clk = 1'b0;
        step();
        pop_due();
        checks++;
        if (tmr0 !== 8'(cnt)) begin
          errors++;
          if (errors < 20) $display("FAIL ext_directed_tmr0 n=%0d: got %h expected %h", n, tmr0, 8'(cnt));
        end
      end
    end
    checks++;
    if (tmr0 !== 8'h0A) begin
      errors++;
      $display("FAIL ext_directed_final: got %h expected 0a", tmr0);
    end
  endtask

  task automatic test_ext_random(input logic se);
    int         ratio;
    logic [7:0] exp_t;
    t0cs = 1'b1;
    t0se = se;
    psa  = 1'($urandom_range(0, 1));
    set_ps($urandom_range(0, 1));
    ratio = psa ? 1 : (2 << {ps2, ps1, ps0});
    t0clk = 1'b0;
    do_reset();
    due.delete();
    cnt = 0;
    for (int e = 0; e < 80 + EXT_LAT; e++) begin
      int w;
      w = (e < 80) ? $urandom_range(2, 5) : 1;
      if (e < 80) begin
        t0clk = ~t0clk;
        if (t0clk != se) due.push_back(n + EXT_LAT);
      end
      for (int p = 0; p < w; p++) begin
        step();
        pop_due();
        exp_t = 8'((cnt / ratio) % 256);
        checks++;
        if (tmr0 !== exp_t) begin
          errors++;
          if (errors < 20) $display("FAIL ext_random_se%0b_tmr0 n=%0d: got %h expected %h", se, n, tmr0, exp_t);
        end
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          if (errors < 20) $display("FAIL ext_random_se%0b_ovf n=%0d: got %b expected 0", se, n, overflow);
        end
      end
    end
  endtask

  task automatic test_ps_change();
    int         m;
    int         ticks;
    logic [7:0] exp_t;
    t0cs = 1'b0;
    psa  = 1'b0;
    set_ps(7);
    do_reset();
    m = $urandom_range(100, 900);
    while (n < m) step();
    checks++;
    if (tmr0 !== 8'h00) begin
      errors++;
      $display("FAIL ps_change_before n=%0d: got %h expected 00", n, tmr0);
    end
    set_ps(0);
    // The edge after the change clears the prescaler and drops its tick.
    for (int i = 0; i < 200; i++) begin
      step();
      ticks = (n > m + 1) ? (n / 4 - (m + 1) / 4) : 0;
      exp_t = 8'(ticks / 2);
      checks++;
      if (tmr0 !== exp_t) begin
        errors++;
        if (errors < 20) $display("FAIL ps_change_tmr0 n=%0d m=%0d: got %h expected %h", n, m, tmr0, exp_t);
      end
    end
  endtask

  task automatic test_reset_midcount();
    int         stop;
    logic [7:0] exp_t;
    t0cs = 1'b0;
    psa  = 1'b1;
    do_reset();
    stop = 360 + $urandom_range(0, 3);
    while (n < stop) step();
    checks++;
    if (tmr0 !== 8'h5A) begin
      errors++;
      $display("FAIL midcount_pre: got %h expected 5a", tmr0);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (tmr0 !== 8'h00) begin
      errors++;
      $display("FAIL midcount_reset_tmr0: got %h expected 00", tmr0);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL midcount_reset_ovf: got %b expected 0", overflow);
    end
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      exp_t = int_model(n, 1);
      checks++;
      if (tmr0 !== exp_t) begin
        errors++;
        if (errors < 20) $display("FAIL midcount_restart n=%0d: got %h expected %h", n, tmr0, exp_t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass_internal();
    test_prescale(2, 8200);
    test_prescale($urandom_range(0, 7), 3000);
    test_prescale($urandom_range(0, 7), 3000);
    test_ext_directed();
    test_ext_random(1'b0);
    test_ext_random(1'b1);
    test_ps_change();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pic_timer0.md
# pic_timer0

PIC16-style Timer0: an 8-bit free-running up-counter with a selectable clock source and a programmable prescaler. The source is the internal instruction clock (fosc/4) or an external T0CKI pin with selectable edge. It sits in the peripheral block of the PIC core. The host drives the OPTION-register bits directly, and the `overflow` output feeds the T0IF interrupt logic.

## Interface
- No parameters. Widths are fixed.
- `fosc` input 1: system clock. Every register updates on its rising edge. This is the block's only clock.
- `rst_n` input 1: reset, synchronous and active-low.
- `ps2`, `ps1`, `ps0` input 1 each: prescaler select PS[2:0].
- `psa` input 1: prescaler assignment. 0 = prescaler feeds TMR0. 1 = bypass, TMR0 counts 1:1.
- `t0cs` input 1: clock source. 0 = internal fosc/4. 1 = external `t0clk`.
- `t0se` input 1: external edge select. 0 = rising edge, 1 = falling edge.
- `t0clk` input 1: T0CKI pin, asynchronous to `fosc`.
- `tmr0` output 8: current count, registered.
- `overflow` output 1: one-`fosc`-cycle pulse on each FF→00 wrap, registered.

## Operation
- **Source tick.**
  - `t0cs=0`: a 2-bit phase counter counts 0..3 every `fosc` cycle. The source tick is asserted when phase==3, giving one tick per 4 `fosc` cycles.
  - `t0cs=1`: `t0clk` is sampled into the `fosc` domain and passed to an edge detector. The selected edge (per `t0se`) produces a source tick of exactly one cycle.
- **Prescaler.** An 8-bit counter.
  - `psa=0`: ratio is 2^(PS+1), covering 1:2 … 1:256. The counter increments on each source tick. When it reaches ratio-1 and a tick arrives, it clears to 0 and the TMR0 increment strobe is issued.
  - `psa=1`: the source tick is the increment strobe directly, and the prescaler counter holds at 0.
- **Prescaler clear on reconfiguration.** If any of {PS[2:0], `psa`, `t0cs`, `t0se`} differs from its value in the previous cycle, the prescaler counter clears to 0. On that cycle no strobe is issued and any pending tick is dropped.
- **Counting.** On each increment strobe, `tmr0` ← `tmr0`+1, modulo 256.
- **Overflow.** `overflow` is 1 in exactly the cycle in which `tmr0` reads 00 after an FF→00 wrap; otherwise it is 0.
- **Reset.** When `rst_n=0` at a rising edge, the following are cleared:
  - `tmr0`=00, `overflow`=0;
  - phase counter, prescaler counter, synchronizer flops and edge history all = 0;
  - the configuration history register is loaded with the current inputs.
- **Reset priority.** Reset dominates every other event in the same cycle. Reset asserted mid-count discards the partial prescale.

## Timing
- **Internal, `psa=1`.** After reset is released, `tmr0` becomes 01 at the 4th rising edge and then increments every 4 cycles.
- **Internal, `psa=0`.** Ratio 1:2^(PS+1) gives one increment every 4·2^(PS+1) cycles. For PS=010 that is every 32 cycles, and the first overflow occurs 8192 cycles after reset.
- **External, with `TIMER0_SYNC_EN`.** `tmr0` updates at the 3rd `fosc` rising edge after the selected `t0clk` edge is first sampled.
- **External, without `TIMER0_SYNC_EN`.** The update occurs at the 2nd `fosc` rising edge.
- **Minimum pin pulse width.** `t0clk` high and low phases must each last at least 2 `fosc` periods, or 1 period without `TIMER0_SYNC_EN`. Shorter pulses may be missed.
- **Overflow pulse.** The pulse coincides with the cycle in which `tmr0` first shows 00. The next pulse cannot occur earlier than 256 strobes later.

## Configuration
- **`TIMER0_SYNC_EN` defined:** `t0clk` passes through a two-flop synchronizer, then one edge-history flop.
- **`TIMER0_SYNC_EN` undefined:** only a single sample flop plus the history flop are used, and `t0clk` must be synchronous to `fosc`. All other behaviour is identical.

## Structure
- **Package `timer0_pkg`:**
  - `TMR_W`=8, `PRE_W`=8;
  - `INSTR_DIV`=4, `PHASE_W`=2;
  - a function mapping PS[2:0] to terminal count 2^(PS+1)-1.
- **Sub-module `timer0_prescaler`:**
  - inputs: source tick, `psa`, PS, clear;
  - output: increment strobe.
- **Top level:** holds the phase counter, synchronizer/edge detect, configuration history, `tmr0` and `overflow`.

## Test plan
- **Bypass, internal clock.** `t0cs=0`, `psa=1`, reset released: `tmr0`=01 after 4 cycles and 0A after 40 cycles. `overflow` pulses for one cycle at cycle 1024, with `tmr0`=00.
- **Prescale 1:8.** `t0cs=0`, `psa=0`, PS=010: `tmr0` increments every 32 cycles. `overflow` pulses at cycle 8192 and `tmr0` reads 00 that cycle.
- **External edges.** `t0cs=1`, `psa=1`:
  - `t0se=0`, 10 rising edges of `t0clk` with period 8·`fosc` → `tmr0`=0A, with each update 3 cycles after the edge;
  - `t0se=1` → counts falling edges only.
- **Prescaler change.** `psa=0`, PS=111; change PS to 000 mid-count → prescaler clears and `tmr0` then increments every 8 cycles.
- **Reset mid-count.** Assert `rst_n=0` for 1 cycle with `tmr0`=5A → `tmr0`=00 and `overflow`=0 on the next edge. Counting restarts from phase 0.
